bcd_countdown: RTL and testbench
================================

Name: bcd_countdown

Overview:
- Four-digit BCD down-counter (mm:ss, 00:00 to 99:59) for the digital clock's countdown/timer mode.
- Loads a BCD start value and decrements once per external tick enable, borrowing digit to digit (seconds-ones, then seconds-tens, then minutes-ones, then minutes-tens).
- On reaching 00:00 it raises a done pulse and a timed alarm.
- Mirror of the up-counting clock path; shares the same tick source and the same display digit format.

Parameters:
ALARM_TICKS, 10, number of tick pulses the alarm output stays high after expiry (1..255)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low; sampled on rising clk edge
- tick  in  1  count enable, one clk wide, nominally 1 Hz
- load  in  1  load load_val into the digits
- load_val  in  16  {min_t, min_o, sec_t, sec_o}, BCD, 4 bits each
- start  in  1  begin or resume counting
- pause  in  1  halt counting, hold value
- clear  in  1  force 00:00 and IDLE
- min_t, min_o, sec_t, sec_o  out  4 each  current value, BCD
- running  out  1  high in RUN
- done  out  1  one-clk pulse on reaching 00:00
- alarm  out  1  high in ALARM
- load_err  out  1  one-clk pulse when a load is rejected

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset values: all digits 0, state IDLE, and running, done, alarm, load_err all 0. Reset mid-count or mid-alarm aborts immediately.
- States:
  - IDLE: start with value ≠ 00:00 goes to RUN. start with value 00:00 is ignored.
  - RUN: pause goes to PAUSE. A tick when value is 00:01 goes to ALARM.
  - PAUSE: start goes to RUN. Ticks are ignored.
  - ALARM: counts ALARM_TICKS ticks, then goes to IDLE. start and pause are ignored.
- Command priority (same cycle): rst_n > clear > load > start > pause > tick.
  - clear: digits 0, state IDLE, alarm 0, from any state.
- Load rules:
  - Accepted only in IDLE or PAUSE. State is unchanged; in PAUSE a later start resumes from the new value.
  - Valid only if every digit ≤ 9 and sec_t ≤ 5.
  - Invalid value: digits unchanged, load_err pulses in the next cycle.
  - Load in RUN or ALARM: ignored, no load_err.
- Decrement (RUN, tick=1):
  - sec_o decrements. 0 wraps to 9 and borrows into sec_t.
  - sec_t: 0 wraps to 5 and borrows into min_o.
  - min_o: 0 wraps to 9 and borrows into min_t.
  - min_t decrements on borrow. Reaching 00:00 is terminal; there is no wrap past 00:00.
- Latency: digits update on the rising edge at which tick is sampled high, so the new value is visible in the following cycle.
  - done asserts in the same cycle the value first reads 00:00.
  - alarm rises with done.
- Alarm timing: alarm falls on the edge after the ALARM_TICKS-th tick counted in ALARM. The expiry tick itself is not counted.
- Simultaneous events:
  - start+pause in PAUSE: resume (start wins).
  - tick+pause in RUN: pause takes effect and the tick is dropped.
  - tick+start in IDLE or PAUSE: enter RUN; that tick is not applied.
- running = (state == RUN), registered.
- Digits never hold a non-BCD value.

Optional Feature:
- Macro: BCD_CD_AUTORELOAD_EN
- Defined:
  - The last accepted load value is kept in a shadow register, reset to 0.
  - When the alarm period ends, the digits reload from the shadow and the state goes to RUN instead of IDLE.
  - If the shadow is 00:00, the block goes to IDLE.
  - clear also zeroes the shadow.
- Undefined: no shadow register. After the alarm the digits stay 00:00 and the state is IDLE.

Test Plan:
- Reset: hold rst_n=0 for 4 clks with tick toggling, release -> digits 00:00, running=0, done=0, alarm=0.
- Borrow chain: load 10:00, start, 1 tick -> 09:59; 59 more ticks -> 09:00; 1 tick -> 08:59.
- Expiry: load 00:03, start, 3 ticks -> 00:00, done high exactly 1 clk, alarm high for exactly 10 further ticks, then state IDLE; a 4th-plus tick leaves digits at 00:00.
- Invalid load: load_val=16'h0A00 in IDLE -> load_err 1-clk pulse, digits unchanged. Then load 16'h0060 -> rejected (sec_t=6). Then load 16'h9959 -> accepted, digits 99:59.
- Pause/priority: RUN at 00:30, assert tick+pause together -> value stays 00:30, PAUSE. Ticks while paused -> no change. start -> next tick gives 00:29. clear during RUN -> 00:00, IDLE. Load during RUN -> ignored, no load_err.
- Autoreload (macro defined): load 00:02, start, 2 ticks plus 10 alarm ticks -> digits 00:02, running=1. Next tick -> 00:01.

Source files
------------

// File: rtl/bcd_countdown.sv
// bcd_countdown: four-digit BCD mm:ss down-counter for the timer mode.
// Loads a start value, decrements once per tick, pulses done and holds
// the alarm for ALARM_TICKS ticks once 00:00 is reached.
// Optional feature macro: BCD_CD_AUTORELOAD_EN (restart from the last
// accepted load value when the alarm period ends).
module bcd_countdown #(
    parameter int ALARM_TICKS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    output logic [3:0]  min_t,
    output logic [3:0]  min_o,
    output logic [3:0]  sec_t,
    output logic [3:0]  sec_o,
    output logic        running,
    output logic        done,
    output logic        alarm,
    output logic        load_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        ALARM
    } state_t;

    localparam logic [7:0] LAST_TICK = 8'(ALARM_TICKS - 1);

    state_t      state, state_nxt;
    logic [15:0] digits, digits_nxt, dec_val;
    logic [7:0]  alarm_cnt, alarm_cnt_nxt;
    logic        done_nxt, load_err_nxt;
    logic        load_ok, is_zero, is_one, can_load;
`ifdef BCD_CD_AUTORELOAD_EN
    logic [15:0] shadow, shadow_nxt;
`endif

    assign load_ok  = (load_val[15:12] <= 4'd9) && (load_val[11:8] <= 4'd9) &&
                      (load_val[7:4]   <= 4'd5) && (load_val[3:0]  <= 4'd9);
    assign is_zero  = (digits == 16'h0000);
    assign is_one   = (digits == 16'h0001);
    assign can_load = (state == IDLE) || (state == PAUSE);

    // One-second decrement with digit-to-digit borrow (only used when value is non-zero)
    always_comb begin
        dec_val = digits;
        if (digits[3:0] != 4'd0) begin
            dec_val[3:0] = digits[3:0] - 4'd1;
        end else begin
            dec_val[3:0] = 4'd9;
            if (digits[7:4] != 4'd0) begin
                dec_val[7:4] = digits[7:4] - 4'd1;
            end else begin
                dec_val[7:4] = 4'd5;
                if (digits[11:8] != 4'd0) begin
                    dec_val[11:8] = digits[11:8] - 4'd1;
                end else begin
                    dec_val[11:8]  = 4'd9;
                    dec_val[15:12] = digits[15:12] - 4'd1;
                end
            end
        end
    end

    // Next state: commands resolved in priority order clear > load > start > pause > tick
    always_comb begin
        state_nxt     = state;
        digits_nxt    = digits;
        alarm_cnt_nxt = alarm_cnt;
        done_nxt      = 1'b0;
        load_err_nxt  = 1'b0;
`ifdef BCD_CD_AUTORELOAD_EN
        shadow_nxt    = shadow;
`endif
        if (clear) begin
            digits_nxt    = 16'h0000;
            state_nxt     = IDLE;
            alarm_cnt_nxt = 8'd0;
`ifdef BCD_CD_AUTORELOAD_EN
            shadow_nxt    = 16'h0000;
`endif
        end else if (load && can_load) begin
            if (load_ok) begin
                digits_nxt = load_val;
`ifdef BCD_CD_AUTORELOAD_EN
                shadow_nxt = load_val;
`endif
            end else begin
                load_err_nxt = 1'b1;
            end
        end else if (start && can_load) begin
            if (!is_zero) begin
                state_nxt = RUN;
            end
        end else if (pause && (state == RUN)) begin
            state_nxt = PAUSE;
        end else if (tick) begin
            case (state)
                RUN: begin
                    if (!is_zero) begin
                        digits_nxt = dec_val;
                    end
                    if (is_one) begin
                        state_nxt     = ALARM;
                        done_nxt      = 1'b1;
                        alarm_cnt_nxt = 8'd0;
                    end
                end
                ALARM: begin
                    if (alarm_cnt == LAST_TICK) begin
                        alarm_cnt_nxt = 8'd0;
`ifdef BCD_CD_AUTORELOAD_EN
                        if (shadow != 16'h0000) begin
                            digits_nxt = shadow;
                            state_nxt  = RUN;
                        end else begin
                            state_nxt  = IDLE;
                        end
`else
                        state_nxt = IDLE;
`endif
                    end else begin
                        alarm_cnt_nxt = alarm_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State, digit and pulse registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            digits    <= 16'h0000;
            alarm_cnt <= 8'd0;
            done      <= 1'b0;
            load_err  <= 1'b0;
`ifdef BCD_CD_AUTORELOAD_EN
            shadow    <= 16'h0000;
`endif
        end else begin
            state     <= state_nxt;
            digits    <= digits_nxt;
            alarm_cnt <= alarm_cnt_nxt;
            done      <= done_nxt;
            load_err  <= load_err_nxt;
`ifdef BCD_CD_AUTORELOAD_EN
            shadow    <= shadow_nxt;
`endif
        end
    end

    assign {min_t, min_o, sec_t, sec_o} = digits;
    assign running = (state == RUN);
    assign alarm   = (state == ALARM);

endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown: self-checking bench for bcd_countdown.
// The reference model keeps the time as a plain number of seconds and
// converts to BCD only for comparison.
module tb_bcd_countdown;

    localparam int ALARM_TICKS = 10;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ALARM = 3;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        load;
    logic [15:0] load_val;
    logic        start;
    logic        pause;
    logic        clear;
    logic [3:0]  min_t, min_o, sec_t, sec_o;
    logic        running, done, alarm, load_err;

    int tests  = 0;
    int failed = 0;

    bcd_countdown #(.ALARM_TICKS(ALARM_TICKS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .min_t    (min_t),
        .min_o    (min_o),
        .sec_t    (sec_t),
        .sec_o    (sec_o),
        .running  (running),
        .done     (done),
        .alarm    (alarm),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int   m_secs   = 0;
    int   m_mode   = M_IDLE;
    int   m_acnt   = 0;
    int   m_shadow = 0;
    logic m_done   = 1'b0;
    logic m_lerr   = 1'b0;
    logic m_valid  = 1'b0;

    function automatic logic [15:0] to_bcd(input int secs);
        int mm;
        int ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] dut_digits();
        return {min_t, min_o, sec_t, sec_o};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of commands, then return just after the sampling edge
    task automatic applyStimulus(input logic t, input logic l, input logic [15:0] lv,
                                 input logic s, input logic p, input logic c);
        tick = t; load = l; load_val = lv; start = s; pause = p; clear = c;
        @(negedge clk);
        #1;
        tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Behavioural model: time in seconds, mode as a small integer
    always @(posedge clk) begin : model
        int   v, md, ac, sh, lv_m, lv_s;
        logic dn, le;
        v = m_secs; md = m_mode; ac = m_acnt; sh = m_shadow;
        dn = 1'b0; le = 1'b0;
        if (!rst_n) begin
            v = 0; md = M_IDLE; ac = 0; sh = 0;
        end else if (clear) begin
            v = 0; md = M_IDLE; ac = 0; sh = 0;
        end else if (load && (md == M_IDLE || md == M_PAUSE)) begin
            if (load_val[15:12] <= 9 && load_val[11:8] <= 9 &&
                load_val[7:4] <= 5 && load_val[3:0] <= 9) begin
                lv_m = int'(load_val[15:12]) * 10 + int'(load_val[11:8]);
                lv_s = int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
                v  = lv_m * 60 + lv_s;
                sh = v;
            end else begin
                le = 1'b1;
            end
        end else if (start && (md == M_IDLE || md == M_PAUSE)) begin
            if (v != 0) md = M_RUN;
        end else if (pause && md == M_RUN) begin
            md = M_PAUSE;
        end else if (tick) begin
            if (md == M_RUN && v > 0) begin
                v = v - 1;
                if (v == 0) begin
                    md = M_ALARM; dn = 1'b1; ac = 0;
                end
            end else if (md == M_ALARM) begin
                ac = ac + 1;
                if (ac == ALARM_TICKS) begin
                    ac = 0;
`ifdef BCD_CD_AUTORELOAD_EN
                    if (sh != 0) begin
                        v = sh; md = M_RUN;
                    end else begin
                        md = M_IDLE;
                    end
`else
                    md = M_IDLE;
`endif
                end
            end
        end
        m_secs <= v; m_mode <= md; m_acnt <= ac; m_shadow <= sh;
        m_done <= dn; m_lerr <= le;
        if (!rst_n) m_valid <= 1'b1;
    end

    // Compare every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("cycle_outputs",
                        {12'h0, dut_digits(), running, done, alarm, load_err},
                        {12'h0, to_bcd(m_secs), m_mode == M_RUN, m_done,
                         m_mode == M_ALARM, m_lerr});
        end
    end

    task automatic pin(input string name, input logic [15:0] digits_exp,
                       input logic run_exp);
        checkOutput({name, "_dut"}, {15'h0, dut_digits(), running},
                    {15'h0, digits_exp, run_exp});
        checkOutput({name, "_model"}, {15'h0, to_bcd(m_secs), m_mode == M_RUN},
                    {15'h0, digits_exp, run_exp});
    endtask

    initial begin
        logic [15:0] rv;
        rst_n = 1'b0; tick = 1'b0; load = 1'b0; load_val = 16'h0;
        start = 1'b0; pause = 1'b0; clear = 1'b0;

        // Reset held with tick toggling
        for (int i = 0; i < 4; i++) begin
            tick = ~tick;
            @(negedge clk);
            #1;
        end
        tick = 1'b0;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        pin("reset", 16'h0000, 1'b0);
        checkOutput("reset_flags", {29'h0, done, alarm, load_err}, 32'h0);

        // Borrow chain
        applyStimulus(1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        ticks(1);
        pin("borrow_0959", 16'h0959, 1'b1);
        ticks(59);
        pin("borrow_0900", 16'h0900, 1'b1);
        ticks(1);
        pin("borrow_0859", 16'h0859, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Expiry and alarm timing
        applyStimulus(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        pin("expiry_zero", 16'h0000, 1'b0);
        checkOutput("expiry_done_alarm", {30'h0, done, alarm}, 32'h3);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("done_one_clk", {30'h0, done, alarm}, 32'h1);
        ticks(9);
        checkOutput("alarm_after_9", {31'h0, alarm}, 32'h1);
        ticks(1);
        checkOutput("alarm_after_10", {31'h0, alarm}, 32'h0);
`ifdef BCD_CD_AUTORELOAD_EN
        pin("expiry_reload", 16'h0003, 1'b1);
`else
        pin("expiry_idle", 16'h0000, 1'b0);
        ticks(2);
        pin("expiry_stays_zero", 16'h0000, 1'b0);
`endif
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Invalid loads
        applyStimulus(1'b0, 1'b1, 16'h0A00, 1'b0, 1'b0, 1'b0);
        checkOutput("lerr_0A00", {31'h0, load_err}, 32'h1);
        pin("lerr_0A00_digits", 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("lerr_pulse_end", {31'h0, load_err}, 32'h0);
        applyStimulus(1'b0, 1'b1, 16'h0060, 1'b0, 1'b0, 1'b0);
        checkOutput("lerr_0060", {31'h0, load_err}, 32'h1);
        applyStimulus(1'b0, 1'b1, 16'h9959, 1'b0, 1'b0, 1'b0);
        checkOutput("load_9959_ok", {31'h0, load_err}, 32'h0);
        pin("load_9959", 16'h9959, 1'b0);

        // Pause and priority
        applyStimulus(1'b0, 1'b1, 16'h0030, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        pin("tick_pause", 16'h0030, 1'b0);
        ticks(3);
        pin("paused_ticks", 16'h0030, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        ticks(1);
        pin("resume_tick", 16'h0029, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
        checkOutput("load_in_run_err", {31'h0, load_err}, 32'h0);
        pin("load_in_run", 16'h0029, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        pin("clear_in_run", 16'h0000, 1'b0);

`ifdef BCD_CD_AUTORELOAD_EN
        // Autoreload restart
        applyStimulus(1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        ticks(2 + ALARM_TICKS);
        pin("autoreload", 16'h0002, 1'b1);
        ticks(1);
        pin("autoreload_tick", 16'h0001, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
`endif

        // Randomized phase against the model
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 9) < 7)
                rv = to_bcd($urandom_range(0, 1) * 60 + $urandom_range(0, 59));
            else
                rv = 16'($urandom);
            applyStimulus($urandom_range(0, 1) == 1,
                          $urandom_range(0, 19) == 0,
                          rv,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 24) == 0,
                          $urandom_range(0, 149) == 0);
            rst_n = 1'b1;
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
